// File: rtl/sample_seq_pkg.sv
// Shared types and defaults for the ADC -> ROM -> DAC sample sequencer.
// The state encoding and default timing live here so the divider and the FSM agree.
package sample_seq_pkg;

    localparam int SAMPLE_W = 10;
    localparam int WAIT_W   = 16;

    localparam int TICK_DIV_DEF    = 2500;
    localparam int ROM_LAT_DEF     = 2;
    localparam int DAC_CYCLES_DEF  = 40;
    localparam int ADC_TIMEOUT_DEF = 200;

    typedef enum logic [2:0] {
        IDLE,
        ADC_START,
        ADC_WAIT,
        ROM_WAIT,
        DAC_START,
        DAC_WAIT
    } state_t;

endpackage

// File: rtl/sample_sequencer_tick_gen.sv
// Sample-period divider: emits a one-cycle tick every TICK_DIV sysclk cycles while enabled.
// With enable low the count parks at 0, so re-enabling always starts a full period.
module tick_gen
    import sample_seq_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic sysclk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int                CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// Runs one ADC capture, ROM lookup and DAC load per sample period, each stage
// starting only after the previous one finishes; flags dropped ticks and ADC timeouts.
module sample_sequencer
    import sample_seq_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int ROM_LAT     = ROM_LAT_DEF,
    parameter int DAC_CYCLES  = DAC_CYCLES_DEF,
    parameter int ADC_TIMEOUT = ADC_TIMEOUT_DEF
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic                enable,
    output logic                adc_start,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic [SAMPLE_W-1:0] rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    output logic                dac_start,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic                busy,
    output logic                overrun,
    output logic                adc_timeout,
    input  logic                clr_flags,
    output logic [15:0]         sample_cnt
);

    localparam logic [WAIT_W-1:0] ADC_LAST = WAIT_W'(ADC_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] ROM_LAST = WAIT_W'(ROM_LAT - 1);
    // DAC_START itself is the first of the DAC_CYCLES cycles.
    localparam logic [WAIT_W-1:0] DAC_LAST = WAIT_W'(DAC_CYCLES - 2);

    state_t            state, state_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic              tick;
    logic              capture_adc, capture_rom, set_timeout, sample_done;
    logic              set_overrun;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .sysclk (sysclk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latch is inferred.
        state_n     = state;
        capture_adc = 1'b0;
        capture_rom = 1'b0;
        set_timeout = 1'b0;
        sample_done = 1'b0;
        case (state)
            IDLE:      if (tick) state_n = ADC_START;
            ADC_START: state_n = ADC_WAIT;
            ADC_WAIT: begin
                // A valid sample on the expiry cycle still wins over the timeout.
                if (adc_valid) begin
                    capture_adc = 1'b1;
                    state_n     = ROM_WAIT;
                end else if (wait_cnt == ADC_LAST) begin
                    set_timeout = 1'b1;
                    state_n     = IDLE;
                end
            end
            ROM_WAIT: begin
                if (wait_cnt == ROM_LAST) begin
                    capture_rom = 1'b1;
                    state_n     = DAC_START;
                end
            end
            DAC_START: state_n = DAC_WAIT;
            DAC_WAIT: begin
                if (wait_cnt == DAC_LAST) begin
                    sample_done = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign set_overrun = tick && (state != IDLE);
    // Gate the strobes with rst so a reset never coincides with a start pulse.
    assign adc_start   = (state == ADC_START) && !rst;
    assign dac_start   = (state == DAC_START) && !rst;
    assign busy        = (state != IDLE);

    always_ff @(posedge sysclk) begin
        // NOTE: non-blocking throughout so every register sees pre-edge values.
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rom_addr    <= '0;
            dac_data    <= '0;
            overrun     <= 1'b0;
            adc_timeout <= 1'b0;
            sample_cnt  <= '0;
        end else begin
            state <= state_n;
            if (state_n != state || state == IDLE) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture_adc) rom_addr <= adc_data;
            if (capture_rom) dac_data <= rom_data;
            overrun     <= set_overrun | (overrun & ~clr_flags);
            adc_timeout <= set_timeout | (adc_timeout & ~clr_flags);
            if (sample_done) sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench: instance a (TICK_DIV=100) covers nominal, timeout, boundary, reset and
// wrap cases; instance b (TICK_DIV=64) covers overrun. Cycle 0 is the first cycle after rst drops.
module tb_sample_sequencer;

    logic        sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic        rst_a, enable_a, adc_valid_a, clr_a, adc_start_a, dac_start_a;
    logic        busy_a, overrun_a, adc_timeout_a;
    logic [9:0]  adc_data_a, rom_addr_a, rom_data_a, dac_data_a;
    logic [15:0] sample_cnt_a;

    logic        rst_b, enable_b, adc_valid_b, clr_b, adc_start_b, dac_start_b;
    logic        busy_b, overrun_b, adc_timeout_b;
    logic [9:0]  adc_data_b, rom_addr_b, rom_data_b, dac_data_b;
    logic [15:0] sample_cnt_b;

    sample_sequencer #(.TICK_DIV(100), .ROM_LAT(2), .DAC_CYCLES(40), .ADC_TIMEOUT(200)) dut_a (
        .sysclk(sysclk), .rst(rst_a), .enable(enable_a), .adc_start(adc_start_a),
        .adc_valid(adc_valid_a), .adc_data(adc_data_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .dac_start(dac_start_a), .dac_data(dac_data_a),
        .busy(busy_a), .overrun(overrun_a), .adc_timeout(adc_timeout_a),
        .clr_flags(clr_a), .sample_cnt(sample_cnt_a)
    );

    sample_sequencer #(.TICK_DIV(64), .ROM_LAT(2), .DAC_CYCLES(40), .ADC_TIMEOUT(200)) dut_b (
        .sysclk(sysclk), .rst(rst_b), .enable(enable_b), .adc_start(adc_start_b),
        .adc_valid(adc_valid_b), .adc_data(adc_data_b), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .dac_start(dac_start_b), .dac_data(dac_data_b),
        .busy(busy_b), .overrun(overrun_b), .adc_timeout(adc_timeout_b),
        .clr_flags(clr_b), .sample_cnt(sample_cnt_b)
    );

    // ADC model: adc_valid lands adc_delay cycles after adc_start (-1 = never).
    // ROM model: registered lookup, data = addr ^ 0x3FF one cycle after rom_addr changes.
    int         adc_delay_a = -1, adc_delay_b = -1;
    int         cd_a = -1, cd_b = -1;
    logic [9:0] rom_pipe_a = '0, rom_pipe_b = '0;

    always @(negedge sysclk) begin
        adc_valid_a = 1'b0;
        if (adc_start_a) cd_a = adc_delay_a;
        else if (cd_a > 0) begin
            cd_a = cd_a - 1;
            if (cd_a == 0) adc_valid_a = 1'b1;
        end
        rom_data_a = rom_pipe_a ^ 10'h3FF;
        rom_pipe_a = rom_addr_a;

        adc_valid_b = 1'b0;
        if (adc_start_b) cd_b = adc_delay_b;
        else if (cd_b > 0) begin
            cd_b = cd_b - 1;
            if (cd_b == 0) adc_valid_b = 1'b1;
        end
        rom_data_b = rom_pipe_b ^ 10'h3FF;
        rom_pipe_b = rom_addr_b;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int na_a = 0, nd_a = 0, na_b = 0;
    int saved;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            cyc++;
            if (adc_start_a) na_a++;
            if (dac_start_a) nd_a++;
            if (adc_start_b) na_b++;
        end
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0:       return adc_start_a;
            1:       return dac_start_a;
            2:       return !busy_a;
            3:       return adc_timeout_a;
            default: return adc_start_b;
        endcase
    endfunction

    // Bounded wait; an expired bound leaves cyc wrong and the caller's cycle check fails.
    task automatic wait_for(input int sel, input int bound);
        for (int i = 0; i < bound; i++) begin
            step(1);
            if (sig(sel)) break;
        end
    endtask

    initial begin
        rst_a = 1'b1; enable_a = 1'b0; clr_a = 1'b0; adc_data_a = '0;
        rst_b = 1'b1; enable_b = 1'b0; clr_b = 1'b0; adc_data_b = '0;
        adc_valid_a = 1'b0; adc_valid_b = 1'b0;
        rom_data_a = '0; rom_data_b = '0;
        repeat (3) @(negedge sysclk);

        check("rst_busy",        {31'd0, busy_a},        32'd0);
        check("rst_adc_start",   {31'd0, adc_start_a},   32'd0);
        check("rst_dac_start",   {31'd0, dac_start_a},   32'd0);
        check("rst_rom_addr",    {22'd0, rom_addr_a},    32'd0);
        check("rst_dac_data",    {22'd0, dac_data_a},    32'd0);
        check("rst_flags",       {30'd0, overrun_a, adc_timeout_a}, 32'd0);
        check("rst_sample_cnt",  {16'd0, sample_cnt_a},  32'd0);

        // Overrun on b: ADC delay 30 makes a sample span 74 cycles against a 64-cycle period.
        adc_delay_b = 30; adc_data_b = 10'h100;
        rst_b = 1'b0; enable_b = 1'b1; cyc = 0;
        wait_for(4, 100);
        check("b_first_adc_start", cyc, 64);
        step(127 - cyc);
        check("b_one_start_in_128", na_b, 1);
        step(1);
        check("b_overrun_set",  {31'd0, overrun_b},  32'd1);
        check("b_dac_data",     {22'd0, dac_data_b}, 32'h2FF);
        step(150 - cyc);
        clr_b = 1'b1;
        step(1);
        clr_b = 1'b0;
        check("b_overrun_cleared", {31'd0, overrun_b}, 32'd0);
        step(255 - cyc);
        clr_b = 1'b1;                 // coincides with the tick dropped at cycle 255
        step(1);
        clr_b = 1'b0;
        check("b_set_beats_clear", {31'd0, overrun_b}, 32'd1);
        check("b_second_start",    na_b, 2);
        check("b_sample_cnt",      {16'd0, sample_cnt_b}, 32'd1);
        enable_b = 1'b0;

        // Nominal sample on a.
        adc_delay_a = 10; adc_data_a = 10'h155;
        rst_a = 1'b0; enable_a = 1'b1; cyc = 0;
        wait_for(0, 200);
        check("nom_adc_start_cycle", cyc, 100);
        step(1);
        check("nom_adc_start_width", {31'd0, adc_start_a}, 32'd0);
        wait_for(1, 50);
        check("nom_dac_start_cycle", cyc, 113);
        check("nom_no_dual_start",   {31'd0, adc_start_a}, 32'd0);
        check("nom_rom_addr",        {22'd0, rom_addr_a},  32'h155);
        check("nom_dac_data",        {22'd0, dac_data_a},  32'h2AA);
        wait_for(2, 100);
        check("nom_busy_low_cycle",  cyc, 153);
        check("nom_sample_cnt",      {16'd0, sample_cnt_a}, 32'd1);
        check("nom_no_overrun",      {31'd0, overrun_a},    32'd0);

        // ADC timeout: ADC_WAIT entered at 201, flag visible 200 cycles later.
        adc_delay_a = -1;
        wait_for(0, 150);
        check("to_adc_start_cycle", cyc, 200);
        wait_for(3, 300);
        check("to_flag_cycle",      cyc, 401);
        check("to_busy_low",        {31'd0, busy_a},     32'd0);
        check("to_no_dac_start",    nd_a, 1);
        check("to_dac_data_held",   {22'd0, dac_data_a}, 32'h2AA);
        check("to_overrun",         {31'd0, overrun_a},  32'd1);

        adc_delay_a = 10; adc_data_a = 10'h0F0;
        wait_for(0, 150);
        check("re_adc_start_cycle", cyc, 500);
        wait_for(1, 50);
        check("re_dac_start_cycle", cyc, 513);
        check("re_dac_data",        {22'd0, dac_data_a}, 32'h30F);
        wait_for(2, 100);
        check("re_busy_low_cycle",  cyc, 553);
        check("re_sample_cnt",      {16'd0, sample_cnt_a}, 32'd2);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        check("clr_flags_both", {30'd0, overrun_a, adc_timeout_a}, 32'd0);
        check("clr_keeps_cnt",  {16'd0, sample_cnt_a}, 32'd2);

        // adc_valid on the expiry cycle (ADC_WAIT entry 601, expiry 800).
        adc_delay_a = 200; adc_data_a = 10'h001;
        wait_for(0, 150);
        check("bnd_adc_start_cycle", cyc, 600);
        wait_for(1, 300);
        check("bnd_dac_start_cycle", cyc, 803);
        check("bnd_no_timeout",      {31'd0, adc_timeout_a}, 32'd0);
        check("bnd_dac_data",        {22'd0, dac_data_a},    32'h3FE);
        wait_for(2, 100);
        check("bnd_sample_cnt",      {16'd0, sample_cnt_a},  32'd3);

        // Reset during ROM_WAIT (adc_valid at 910, ROM_WAIT at 911).
        adc_delay_a = 10; adc_data_a = 10'h2C3;
        wait_for(0, 150);
        check("rw_adc_start_cycle", cyc, 900);
        step(11);
        check("rw_in_rom_wait",     {22'd0, rom_addr_a}, 32'h2C3);
        rst_a = 1'b1;
        saved = nd_a;
        step(1);
        rst_a = 1'b0;
        check("rw_busy",       {31'd0, busy_a},       32'd0);
        check("rw_rom_addr",   {22'd0, rom_addr_a},   32'd0);
        check("rw_dac_data",   {22'd0, dac_data_a},   32'd0);
        check("rw_no_dac",     nd_a - saved,          32'd0);
        check("rw_no_adc",     {31'd0, adc_start_a},  32'd0);
        check("rw_sample_cnt", {16'd0, sample_cnt_a}, 32'd0);
        check("rw_overrun",    {31'd0, overrun_a},    32'd0);
        cyc = 0;

        // Tick counter restarts from 0; then sample_cnt wrap and enable drop mid-sample.
        adc_data_a = 10'h155;
        wait_for(0, 200);
        check("rw_restart_cycle", cyc, 100);
        force dut_a.sample_cnt = 16'hFFFF;
        step(1);
        release dut_a.sample_cnt;
        check("wrap_preload", {16'd0, sample_cnt_a}, 32'hFFFF);
        wait_for(1, 50);
        check("wrap_dac_start_cycle", cyc, 113);
        step(5);
        enable_a = 1'b0;
        wait_for(2, 100);
        check("dis_completes_cycle", cyc, 153);
        check("wrap_sample_cnt",     {16'd0, sample_cnt_a}, 32'd0);
        saved = na_a;
        step(300);
        check("dis_no_new_start", na_a - saved, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
- Sequences the ADC -> ROM -> DAC sample path once per sample period.
- Issues a start pulse to spi2adc and waits for data_valid.
- Presents the captured sample as the ROM address and waits the ROM read latency.
- Starts spi2dac and holds the DAC word for the full transfer.
- Replaces the free-running tick fan-out, so every stage is triggered only after the previous stage has completed.
- Reports overruns and ADC timeouts.

Parameters:
- TICK_DIV, 2500, sysclk cycles per sample period (50 MHz / 2500 = 20 kHz); minimum 64.
- ROM_LAT, 2, sysclk cycles from rom_addr change to valid rom_data (address register plus one clocked ROM stage).
- DAC_CYCLES, 40, sysclk cycles from dac_start to completion of the spi2dac frame.
- ADC_TIMEOUT, 200, maximum sysclk cycles to wait for adc_valid after adc_start.

Ports:
- sysclk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, allows tick generation; 0 stops new periods.
- adc_start, output, 1, one-cycle start pulse to spi2adc.
- adc_valid, input, 1, data_valid from spi2adc.
- adc_data, input, 10, data_from_adc.
- rom_addr, output, 10, registered ROM address.
- rom_data, input, 10, ROM output.
- dac_start, output, 1, one-cycle load pulse to spi2dac and pwm.
- dac_data, output, 10, registered DAC word, held stable between loads.
- busy, output, 1, high in any state other than IDLE.
- overrun, output, 1, sticky; set when a tick arrives while busy.
- adc_timeout, output, 1, sticky; set when ADC_WAIT expires.
- clr_flags, input, 1, clears overrun and adc_timeout.
- sample_cnt, output, 16, number of completed DAC loads; wraps from 0xFFFF to 0.

Behaviour:
- Clocking and reset:
  - Single clock domain: sysclk.
  - rst is synchronous and active-high, sampled on the rising edge.
  - Reset values: state IDLE; tick counter 0; adc_start 0; dac_start 0; rom_addr 0; dac_data 0; busy 0; overrun 0; adc_timeout 0; sample_cnt 0.
  - Reset mid-operation aborts the current sample. No start pulse is emitted on the reset cycle or the cycle after it.
- Tick generation:
  - When enable=1, the counter runs 0..TICK_DIV-1.
  - tick is asserted for one cycle when the count equals TICK_DIV-1; the counter then wraps to 0.
  - When enable=0, the counter holds at 0 and no tick is produced. An in-flight sample still completes.
- State machine:
  - IDLE: on tick, go to ADC_START.
  - ADC_START: adc_start=1 for exactly this cycle; go to ADC_WAIT and load the wait counter with 0.
  - ADC_WAIT:
    - If adc_valid=1, capture rom_addr <= adc_data and go to ROM_WAIT.
    - Otherwise, if the wait counter equals ADC_TIMEOUT-1, set adc_timeout and go to IDLE; the DAC is not written.
    - If adc_valid arrives on the same cycle as expiry, adc_valid wins.
  - ROM_WAIT: count ROM_LAT cycles after the rom_addr update. On the last count, capture dac_data <= rom_data and go to DAC_START.
  - DAC_START: dac_start=1 for this cycle only; go to DAC_WAIT.
  - DAC_WAIT: count DAC_CYCLES-1 further cycles, then go to IDLE and increment sample_cnt.
- Latency:
  - From tick to adc_start: 1 cycle.
  - From adc_valid to dac_start: ROM_LAT+1 cycles.
- Overrun handling:
  - A tick that arrives while state is not IDLE is dropped and sets overrun.
  - The in-flight sample is not disturbed.
- Flag priority:
  - If clr_flags and a set condition occur in the same cycle, set wins.
  - clr_flags has no effect on sample_cnt.
- Signal rules:
  - adc_valid is ignored outside ADC_WAIT.
  - adc_start and dac_start are never asserted in the same cycle.
  - rom_addr and dac_data change only at their capture points.

Decomposition:
- Shared package sample_seq_pkg holds:
  - the state enum (IDLE, ADC_START, ADC_WAIT, ROM_WAIT, DAC_START, DAC_WAIT);
  - the SAMPLE_W=10 constant;
  - the default TICK_DIV, ROM_LAT, DAC_CYCLES and ADC_TIMEOUT values.
- One sub-module, tick_gen: parameterised divider with enable and synchronous reset, outputting a one-cycle tick.
- The FSM, its wait counters, the flags and sample_cnt stay in sample_sequencer.

Test Plan:
1. Nominal sample, TICK_DIV=100, ROM_LAT=2:
   - Stimulus: enable=1; the ADC model returns 0x155 with adc_valid 10 cycles after adc_start; the ROM model returns addr XOR 0x3FF.
   - Required: adc_start at cycle 100; dac_start 3 cycles after adc_valid; dac_data=0x2AA; sample_cnt=1; busy low after DAC_CYCLES.
2. ADC timeout:
   - Stimulus: adc_valid never asserted.
   - Required: adc_timeout set exactly ADC_TIMEOUT cycles after ADC_WAIT entry; no dac_start; dac_data unchanged; the next tick restarts normally.
3. Overrun, TICK_DIV=64, DAC_CYCLES=40, ADC delay 30:
   - Required: the second tick arrives while busy; overrun=1; that tick is dropped, so only one adc_start is seen in the first 128 cycles.
   - Then clr_flags coinciding with a fresh overrun: overrun stays 1.
4. Reset mid-operation:
   - Stimulus: assert rst for 1 cycle during ROM_WAIT.
   - Required: next cycle state IDLE, rom_addr=0, dac_data=0, no dac_start, counters 0.
5. Timeout boundary:
   - Stimulus: adc_valid on the exact expiry cycle.
   - Required: sample captured, adc_timeout stays 0, dac_start follows.
6. Enable and wrap:
   - Stimulus: enable=0 during DAC_WAIT.
   - Required: the in-flight sample completes and no further adc_start appears.
   - Preload sample_cnt to 0xFFFF via 65536 fast samples (or force); the next completion gives 0x0000.
